// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage MIPS core: latches decoded operands and control,
// decodes the ALU control word, forwards EX/MEM and MEM/WB results, and bubbles on load-use.
module id_ex_stage #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [DATA_W-1:0] id_rs_data,
   input  logic [DATA_W-1:0] id_rt_data,
   input  logic [DATA_W-1:0] id_imm,
   input  logic [REG_W-1:0]  id_rs,
   input  logic [REG_W-1:0]  id_rt,
   input  logic [REG_W-1:0]  id_rd,
   input  logic [1:0]        id_alu_op,
   input  logic [5:0]        id_funct,
   input  logic              id_alu_src,
   input  logic              id_reg_dst,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic              id_mem_write,
   input  logic              id_mem_to_reg,
   input  logic              flush,
   input  logic              mem_reg_write,
   input  logic [REG_W-1:0]  mem_rd,
   input  logic [DATA_W-1:0] mem_result,
   input  logic              wb_reg_write,
   input  logic [REG_W-1:0]  wb_rd,
   input  logic [DATA_W-1:0] wb_result,
   output logic              stall,
   output logic              ex_valid,
   output logic [DATA_W-1:0] operand_a,
   output logic [DATA_W-1:0] operand_b,
   output logic [3:0]        alu_control,
   output logic [DATA_W-1:0] ex_store_data,
   output logic [REG_W-1:0]  ex_write_reg,
   output logic              ex_reg_write,
   output logic              ex_mem_read,
   output logic              ex_mem_write,
   output logic              ex_mem_to_reg
);

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_NOR = 4'b1100;
   localparam logic [3:0] ALU_NOP = 4'b1111;

   logic [DATA_W-1:0] ex_rs_data;
   logic [DATA_W-1:0] ex_rt_data;
   logic [DATA_W-1:0] ex_imm;
   logic [REG_W-1:0]  ex_rs;
   logic [REG_W-1:0]  ex_rt;
   logic              ex_alu_src;
   logic [3:0]        alu_decoded;
   logic              load_bubble;
   logic [DATA_W-1:0] fwd_rs;
   logic [DATA_W-1:0] fwd_rt;

   // Unknown funct codes map to a code the ALU treats as "produce zero".
   always_comb begin
      alu_decoded = ALU_ADD;
      unique case (id_alu_op)
         2'b00: alu_decoded = ALU_ADD;
         2'b01: alu_decoded = ALU_SUB;
         2'b11: alu_decoded = ALU_OR;
         default: begin
            unique case (id_funct)
               6'b100000: alu_decoded = ALU_ADD;
               6'b100010: alu_decoded = ALU_SUB;
               6'b100100: alu_decoded = ALU_AND;
               6'b100101: alu_decoded = ALU_OR;
               6'b100111: alu_decoded = ALU_NOR;
               6'b101010: alu_decoded = ALU_SLT;
               default:   alu_decoded = ALU_NOP;
            endcase
         end
      endcase
   end

   assign stall = id_valid && ex_valid && ex_mem_read && (ex_write_reg != '0) &&
                  ((ex_write_reg == id_rs) || (ex_write_reg == id_rt));

   assign load_bubble = flush || stall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid      <= 1'b0;
         ex_rs_data    <= '0;
         ex_rt_data    <= '0;
         ex_imm        <= '0;
         ex_rs         <= '0;
         ex_rt         <= '0;
         ex_write_reg  <= '0;
         alu_control   <= '0;
         ex_alu_src    <= 1'b0;
         ex_reg_write  <= 1'b0;
         ex_mem_read   <= 1'b0;
         ex_mem_write  <= 1'b0;
         ex_mem_to_reg <= 1'b0;
      end else if (load_bubble) begin
         ex_valid      <= 1'b0;
         ex_rs_data    <= '0;
         ex_rt_data    <= '0;
         ex_imm        <= '0;
         ex_rs         <= '0;
         ex_rt         <= '0;
         ex_write_reg  <= '0;
         alu_control   <= '0;
         ex_alu_src    <= 1'b0;
         ex_reg_write  <= 1'b0;
         ex_mem_read   <= 1'b0;
         ex_mem_write  <= 1'b0;
         ex_mem_to_reg <= 1'b0;
      end else begin
         ex_valid      <= id_valid;
         ex_rs_data    <= id_rs_data;
         ex_rt_data    <= id_rt_data;
         ex_imm        <= id_imm;
         ex_rs         <= id_rs;
         ex_rt         <= id_rt;
         ex_write_reg  <= id_reg_dst ? id_rd : id_rt;
         alu_control   <= alu_decoded;
         ex_alu_src    <= id_valid && id_alu_src;
         ex_reg_write  <= id_valid && id_reg_write;
         ex_mem_read   <= id_valid && id_mem_read;
         ex_mem_write  <= id_valid && id_mem_write;
         ex_mem_to_reg <= id_valid && id_mem_to_reg;
      end
   end

   // EX/MEM is the younger producer, so it takes priority; register 0 is never forwarded.
   always_comb begin
      fwd_rs = ex_rs_data;
      if (mem_reg_write && (mem_rd != '0) && (mem_rd == ex_rs))
         fwd_rs = mem_result;
      else if (wb_reg_write && (wb_rd != '0) && (wb_rd == ex_rs))
         fwd_rs = wb_result;
   end

   always_comb begin
      fwd_rt = ex_rt_data;
      if (mem_reg_write && (mem_rd != '0) && (mem_rd == ex_rt))
         fwd_rt = mem_result;
      else if (wb_reg_write && (wb_rd != '0) && (wb_rd == ex_rt))
         fwd_rt = wb_result;
   end

   assign operand_a     = fwd_rs;
   assign operand_b     = ex_alu_src ? ex_imm : fwd_rt;
   assign ex_store_data = fwd_rt;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage MIPS core, directly upstream of the ALU.
- Latches decoded operands and control from ID, decodes the 4-bit ALU control word, and applies EX forwarding muxes that feed the ALU operand A/B inputs.
- Detects load-use hazards, stalls ID/IF, and inserts bubbles.

Parameters:
- DATA_W, 32, datapath width (operands, immediate, forwarded results)
- REG_W, 5, register-specifier width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs_data, id_rt_data  in  DATA_W  register-file read data
- id_imm  in  DATA_W  sign-extended immediate
- id_rs, id_rt, id_rd  in  REG_W  register specifiers
- id_alu_op  in  2  00 add, 01 sub, 10 R-type (use funct), 11 or
- id_funct  in  6  instruction funct field
- id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1 each  ID control
- flush  in  1  branch/jump squash of the instruction in ID
- mem_reg_write  in  1  EX/MEM instruction writes a register
- mem_rd  in  REG_W  EX/MEM destination register
- mem_result  in  DATA_W  EX/MEM ALU result
- wb_reg_write  in  1  MEM/WB instruction writes a register
- wb_rd  in  REG_W  MEM/WB destination register
- wb_result  in  DATA_W  MEM/WB writeback value
- stall  out  1  load-use hazard: IF/ID must hold
- ex_valid  out  1  EX holds a real instruction
- operand_a, operand_b  out  DATA_W  ALU inputs
- alu_control  out  4  ALU function code
- ex_store_data  out  DATA_W  forwarded rt value for stores
- ex_write_reg  out  REG_W  destination (rd if reg_dst, else rt)
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1 each  registered control

Behaviour:
- Reset (async, rst_n low): every register clears to 0. Outputs: ex_valid=0, all ex_* control=0, ex_write_reg=0, alu_control=0000, stall=0; operand_a/operand_b/ex_store_data=0 (no forward matches register 0).
- stall (combinational): id_valid & ex_valid & ex_mem_read & ex_write_reg!=0 & (ex_write_reg==id_rs | ex_write_reg==id_rt).
- Per rising edge, in priority order:
  - flush: load bubble (valid=0, all control=0).
  - else stall: load bubble; ID holds externally, so the same instruction re-enters next cycle.
  - else: load all ID fields; valid=id_valid; control gated to 0 when id_valid=0.
  - Bubble data/specifier registers load 0.
- Exactly one bubble per load-use. At most one stall cycle per load; the following cycle forwards from MEM/WB.
- Write register is latched as id_reg_dst ? id_rd : id_rt.
- alu_control is registered and decoded at ID->EX load:
  - alu_op 00 -> 0010; 01 -> 0110; 11 -> 0001.
  - alu_op 10 by funct: 100000->0010, 100010->0110, 100100->0000, 100101->0001, 100111->1100, 101010->0111, other->1111 (ALU yields 0).
- Forwarding (combinational from registered ex_rs/ex_rt, per operand):
  - EX/MEM match (mem_reg_write & mem_rd!=0 & mem_rd==src): use mem_result.
  - else MEM/WB match (same rules with wb_*): use wb_result.
  - else use the latched register data.
  - Both matching: EX/MEM wins (youngest). Register 0 is never forwarded.
- operand_a = forwarded rs.
- operand_b = ex_alu_src ? latched imm : forwarded rt.
- ex_store_data = forwarded rt, independent of alu_src.
- Simultaneous flush and stall: flush wins; stall output still reflects the hazard combinationally.
- Reset mid-stall: stall drops as soon as ex_valid clears.
- Latency: 1 cycle from ID to ALU inputs.

Test Plan:
- Reset: rst_n=0 mid-cycle with valid instruction in EX -> ex_valid=0, alu_control=0000, stall=0 immediately, without waiting for clk.
- R-type add r3=r1+r2 (funct 100000, rs_data=5, rt_data=7, reg_dst=1, rd=3), no hazards -> next cycle: operand_a=5, operand_b=7, alu_control=0010, ex_write_reg=3.
- Forward priority: EX has rs=4; mem_rd=4 mem_result=0xAA; wb_rd=4 wb_result=0xBB -> operand_a=0xAA. Drop mem_reg_write -> operand_a=0xBB. Set mem_rd=0 with rs=0 -> no forward, operand_a=latched data.
- Load-use: lw writing r8 in EX, ID instruction with rs=8 -> stall=1 for exactly one cycle, bubble loaded (ex_valid=0, ex_reg_write=0). Next cycle: same instruction enters, forwarded from wb_result.
- Flush during stall: flush=1 and stall=1 -> bubble loaded, ex_mem_write=0.
- ALU decode sweep: funct 100010/100100/100101/100111/101010/000000 -> alu_control 0110/0000/0001/1100/0111/1111. I-type sw with alu_src=1, imm=0xFFFFFFFC, rt forwarded=0x1234 -> operand_b=0xFFFFFFFC, ex_store_data=0x1234.
